// File: rtl/accel_ram_ide_pkg.sv
// Shared definitions for the SPI port controller: register map, CTRL/STATUS
// bit positions and the transfer FSM state encoding.
// No ports (package).
package accel_ram_ide_pkg;

  // Register addresses
  localparam logic [1:0] AddrData   = 2'd0;
  localparam logic [1:0] AddrCtrl   = 2'd1;
  localparam logic [1:0] AddrStatus = 2'd2;
  localparam logic [1:0] AddrRsvd   = 2'd3;

  // CTRL bit positions ([2:0] is DIV)
  localparam int unsigned CtrlCsEn  = 3;
  localparam int unsigned CtrlIoLsb = 4;

  // STATUS bit positions
  localparam int unsigned StatBusy = 0;
  localparam int unsigned StatDone = 1;
  localparam int unsigned StatOvr  = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLow  = 2'd1,
    StHigh = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_sck_timer.sv
// SCK phase timer: counts cycles within one SCK phase and pulses phase_end on
// the last cycle of a phase (each phase lasts DIV+1 cycles).
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   div         - divider value from CTRL
//   start       - transfer accepted this cycle (restarts the count, latches div)
//   run         - a transfer is in progress
//   phase_end   - last cycle of the current SCK phase
module spi_sck_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] div,
  input  logic       start,
  input  logic       run,
  output logic       phase_end
);

  logic [2:0] cnt;
  logic [2:0] div_lat;

  assign phase_end = run && (cnt == div_lat);

  // div is only sampled at phase boundaries so a mid-transfer DIV change
  // never shortens or stretches the phase already in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 3'd0;
      div_lat <= 3'd0;
    end else if (start || phase_end) begin
      cnt     <= 3'd0;
      div_lat <= div;
    end else if (run) begin
      cnt <= cnt + 3'd1;
    end
  end

endmodule

// File: rtl/spi_port_controller.sv
// SPI mode-0 master with a small register interface and two GPIO outputs.
// Ports:
//   CPU_CLK, RESET_n            - clock, asynchronous active-low reset
//   REG_SEL/WR/ADDR/WDATA       - register access request (held until REG_ACK)
//   REG_RDATA, REG_ACK          - read data and one-cycle acknowledge
//   SPI_CS_n/SCK/MOSI, SPI_MISO - SPI pins (CS_n is software driven only)
//   IO_PORT                     - general-purpose outputs from CTRL[5:4]
module spi_port_controller
  import accel_ram_ide_pkg::*;
#(
  parameter logic [2:0] DEFAULT_DIV = 3'd7
) (
  input  logic       CPU_CLK,
  input  logic       RESET_n,
  input  logic       REG_SEL,
  input  logic       REG_WR,
  input  logic [1:0] REG_ADDR,
  input  logic [7:0] REG_WDATA,
  output logic [7:0] REG_RDATA,
  output logic       REG_ACK,
  output logic       SPI_CS_n,
  output logic       SPI_SCK,
  output logic       SPI_MOSI,
  input  logic       SPI_MISO,
  output logic [1:0] IO_PORT
);

  spi_state_e state;
  logic       armed;
  logic [2:0] div;
  logic       done;
  logic       ovr;
  logic [7:0] data_rd;
  logic [7:0] rx;
  logic [6:0] tx;      // bits still to send after the one on MOSI
  logic [2:0] bit_cnt;
  logic [7:0] rd_mux;

  logic accept, busy, wr_data, rd_data, start, phase_end, xfer_done;

  // One access per REG_SEL assertion; rearmed once REG_SEL is seen low.
  assign accept    = REG_SEL && armed;
  assign busy      = (state != StIdle);
  assign wr_data   = accept && REG_WR && (REG_ADDR == AddrData);
  assign rd_data   = accept && !REG_WR && (REG_ADDR == AddrData);
  assign start     = wr_data && !busy;
  assign xfer_done = (state == StHigh) && phase_end && (bit_cnt == 3'd7);

  spi_sck_timer u_sck_timer (
    .clk       (CPU_CLK),
    .rst_n     (RESET_n),
    .div       (div),
    .start     (start),
    .run       (busy),
    .phase_end (phase_end)
  );

  always_comb begin
    rd_mux = 8'h00;
    case (REG_ADDR)
      AddrData: rd_mux = data_rd;
      AddrCtrl: begin
        rd_mux[2:0]             = div;
        rd_mux[CtrlCsEn]        = ~SPI_CS_n;
        rd_mux[CtrlIoLsb +: 2]  = IO_PORT;
      end
      AddrStatus: begin
        rd_mux[StatBusy] = busy;
        rd_mux[StatDone] = done;
        rd_mux[StatOvr]  = ovr;
      end
      default: rd_mux = 8'h00;
    endcase
  end

  // Transfer FSM with registered pin outputs.
  always_ff @(posedge CPU_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state    <= StIdle;
      SPI_SCK  <= 1'b0;
      SPI_MOSI <= 1'b1;
      tx       <= 7'h00;
      rx       <= 8'h00;
      bit_cnt  <= 3'd0;
    end else begin
      case (state)
        StIdle: begin
          if (start) begin
            state    <= StLow;
            SPI_SCK  <= 1'b0;
            SPI_MOSI <= REG_WDATA[7];
            tx       <= REG_WDATA[6:0];
            bit_cnt  <= 3'd0;
          end
        end
        StLow: begin
          if (phase_end) begin
            SPI_SCK <= 1'b1;
            rx      <= {rx[6:0], SPI_MISO};
            state   <= StHigh;
          end
        end
        StHigh: begin
          if (phase_end) begin
            SPI_SCK <= 1'b0;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state    <= StIdle;
              SPI_MOSI <= 1'b1;
            end else begin
              SPI_MOSI <= tx[6];
              tx       <= {tx[5:0], 1'b0};
              state    <= StLow;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Register file and access handshake.
  always_ff @(posedge CPU_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      armed     <= 1'b1;
      REG_ACK   <= 1'b0;
      REG_RDATA <= 8'h00;
      div       <= DEFAULT_DIV;
      SPI_CS_n  <= 1'b1;
      IO_PORT   <= 2'b00;
      done      <= 1'b0;
      ovr       <= 1'b0;
      data_rd   <= 8'h00;
    end else begin
      REG_ACK   <= accept;
      REG_RDATA <= (accept && !REG_WR) ? rd_mux : 8'h00;

      if (!REG_SEL) begin
        armed <= 1'b1;
      end else if (accept) begin
        armed <= 1'b0;
      end

      if (accept && REG_WR && (REG_ADDR == AddrCtrl)) begin
        div      <= REG_WDATA[2:0];
        SPI_CS_n <= ~REG_WDATA[CtrlCsEn];
        IO_PORT  <= REG_WDATA[CtrlIoLsb +: 2];
      end

      if (xfer_done) begin
        data_rd <= rx;
      end

      // Completion wins over a coincident DATA read; the read sees the old byte.
      if (xfer_done) begin
        done <= 1'b1;
      end else if (rd_data) begin
        done <= 1'b0;
      end

      if (wr_data && busy) begin
        ovr <= 1'b1;
      end else if (accept && REG_WR && (REG_ADDR == AddrStatus)) begin
        ovr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_port_controller.sv
module tb_spi_port_controller;
  import accel_ram_ide_pkg::*;

  logic       CPU_CLK = 1'b0;
  logic       RESET_n = 1'b0;
  logic       REG_SEL = 1'b0;
  logic       REG_WR = 1'b0;
  logic [1:0] REG_ADDR = 2'd0;
  logic [7:0] REG_WDATA = 8'h00;
  logic [7:0] REG_RDATA;
  logic       REG_ACK;
  logic       SPI_CS_n, SPI_SCK, SPI_MOSI, SPI_MISO;
  logic [1:0] IO_PORT;

  spi_port_controller #(.DEFAULT_DIV(3'd7)) dut (
    .CPU_CLK   (CPU_CLK),
    .RESET_n   (RESET_n),
    .REG_SEL   (REG_SEL),
    .REG_WR    (REG_WR),
    .REG_ADDR  (REG_ADDR),
    .REG_WDATA (REG_WDATA),
    .REG_RDATA (REG_RDATA),
    .REG_ACK   (REG_ACK),
    .SPI_CS_n  (SPI_CS_n),
    .SPI_SCK   (SPI_SCK),
    .SPI_MOSI  (SPI_MOSI),
    .SPI_MISO  (SPI_MISO),
    .IO_PORT   (IO_PORT)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge CPU_CLK) cyc <= cyc + 1;

  // SPI line observer and a simple slave that shifts out slave_byte MSB first.
  logic       sck_prev = 1'b0;
  bit         mosi_q[$];
  int         rise_q[$];
  int         fall_cnt = 0;
  int         fall_base = 0;
  int         last_fall_cyc = 0;
  logic [7:0] slave_byte = 8'h00;
  bit         loop_mode = 1'b0;
  logic [2:0] sidx;

  assign sidx     = 3'(fall_cnt - fall_base);
  assign SPI_MISO = loop_mode ? SPI_MOSI : slave_byte[3'd7 - sidx];

  always @(negedge CPU_CLK) begin
    if (SPI_SCK && !sck_prev) begin
      mosi_q.push_back(SPI_MOSI);
      rise_q.push_back(cyc);
    end
    if (!SPI_SCK && sck_prev) begin
      fall_cnt      <= fall_cnt + 1;
      last_fall_cyc <= cyc;
    end
    sck_prev <= SPI_SCK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic access(input bit wr, input logic [1:0] addr, input logic [7:0] wd,
                        output logic [7:0] rd);
    bit got = 1'b0;
    rd = 8'h00;
    @(negedge CPU_CLK);
    REG_SEL   = 1'b1;
    REG_WR    = wr;
    REG_ADDR  = addr;
    REG_WDATA = wd;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge CPU_CLK);
      if (REG_ACK) begin
        got = 1'b1;
        rd  = REG_RDATA;
      end
    end
    REG_SEL = 1'b0;
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL ack_timeout: got no REG_ACK expected REG_ACK (addr %0d)", addr);
    end
  endtask

  task automatic wreg(input logic [1:0] addr, input logic [7:0] wd);
    logic [7:0] d;
    access(1'b1, addr, wd, d);
  endtask

  task automatic rreg(input logic [1:0] addr, output logic [7:0] rd);
    access(1'b0, addr, 8'h00, rd);
  endtask

  // Accept a DATA write and confirm BUSY is visible right after.
  task automatic start_xfer(input string name, input logic [7:0] tx, input bit loop,
                            input logic [7:0] sb, output int acc);
    logic [7:0] st;
    loop_mode  = loop;
    slave_byte = sb;
    fall_base  = fall_cnt;
    mosi_q.delete();
    rise_q.delete();
    wreg(AddrData, tx);
    acc = cyc;
    rreg(AddrStatus, st);
    check({name, "_busy"}, 32'(st[0]), 32'd1);
  endtask

  task automatic wait_falls(input string name, input int n);
    int guard = 0;
    while ((fall_cnt - fall_base) < n && guard < 300) begin
      @(negedge CPU_CLK);
      guard++;
    end
    check({name, "_wait"}, 32'(guard < 300), 32'd1);
  endtask

  // Expected values follow from the protocol: 8 bits, two phases of DIV+1 cycles each.
  task automatic finish_xfer(input string name, input int div, input logic [7:0] tx,
                             input logic [7:0] exp_rx, input int acc, input logic [7:0] exp_st);
    logic [7:0] rd;
    logic [7:0] m = 8'h00;
    wait_falls(name, 8);
    @(negedge CPU_CLK);
    check({name, "_len"}, 32'(last_fall_cyc - acc), 32'(16 * (div + 1)));
    check({name, "_nbits"}, 32'(mosi_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < mosi_q.size(); i++) m = {m[6:0], mosi_q[i]};
    check({name, "_mosi"}, 32'(m), 32'(tx));
    if (rise_q.size() >= 2)
      check({name, "_period"}, 32'(rise_q[1] - rise_q[0]), 32'(2 * (div + 1)));
    check({name, "_sck_idle"}, 32'(SPI_SCK), 32'd0);
    check({name, "_mosi_idle"}, 32'(SPI_MOSI), 32'd1);
    rreg(AddrStatus, rd);
    check({name, "_status"}, 32'(rd), 32'(exp_st));
    rreg(AddrData, rd);
    check({name, "_rx"}, 32'(rd), 32'(exp_rx));
    rreg(AddrStatus, rd);
    check({name, "_status_after"}, 32'(rd), 32'(exp_st & 8'hFD));
  endtask

  typedef struct {
    bit         wr;
    logic [1:0] addr;
    logic [7:0] wd;
    logic [7:0] exp_rd;
    logic       exp_cs_n;
    logic [1:0] exp_io;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [7:0] rd;
    int acc, nack;

    vecs[0]  = '{1'b0, AddrCtrl,   8'h00, 8'h07, 1'b1, 2'd0};
    vecs[1]  = '{1'b0, AddrStatus, 8'h00, 8'h00, 1'b1, 2'd0};
    vecs[2]  = '{1'b0, AddrData,   8'h00, 8'h00, 1'b1, 2'd0};
    vecs[3]  = '{1'b0, AddrRsvd,   8'h00, 8'h00, 1'b1, 2'd0};
    vecs[4]  = '{1'b1, AddrCtrl,   8'h38, 8'h00, 1'b0, 2'd3};
    vecs[5]  = '{1'b0, AddrCtrl,   8'h00, 8'h38, 1'b0, 2'd3};
    vecs[6]  = '{1'b1, AddrCtrl,   8'hFF, 8'h00, 1'b0, 2'd3};
    vecs[7]  = '{1'b0, AddrCtrl,   8'h00, 8'h3F, 1'b0, 2'd3};
    vecs[8]  = '{1'b1, AddrRsvd,   8'hAA, 8'h00, 1'b0, 2'd3};
    vecs[9]  = '{1'b0, AddrRsvd,   8'h00, 8'h00, 1'b0, 2'd3};
    vecs[10] = '{1'b1, AddrStatus, 8'hFF, 8'h00, 1'b0, 2'd3};
    vecs[11] = '{1'b0, AddrStatus, 8'h00, 8'h00, 1'b0, 2'd3};
    vecs[12] = '{1'b1, AddrCtrl,   8'h17, 8'h00, 1'b1, 2'd1};
    vecs[13] = '{1'b0, AddrCtrl,   8'h00, 8'h17, 1'b1, 2'd1};
    vecs[14] = '{1'b1, AddrCtrl,   8'h07, 8'h00, 1'b1, 2'd0};
    vecs[15] = '{1'b0, AddrCtrl,   8'h00, 8'h07, 1'b1, 2'd0};

    // Reset state of the pins
    repeat (3) @(negedge CPU_CLK);
    #1;
    check("rst_sck", 32'(SPI_SCK), 32'd0);
    check("rst_mosi", 32'(SPI_MOSI), 32'd1);
    check("rst_cs_n", 32'(SPI_CS_n), 32'd1);
    check("rst_io", 32'(IO_PORT), 32'd0);
    check("rst_ack", 32'(REG_ACK), 32'd0);
    check("rst_rdata", 32'(REG_RDATA), 32'd0);
    @(negedge CPU_CLK);
    RESET_n = 1'b1;

    // Register map table
    for (int i = 0; i < 16; i++) begin
      access(vecs[i].wr, vecs[i].addr, vecs[i].wd, rd);
      if (!vecs[i].wr) check($sformatf("vec%0d_rd", i), 32'(rd), 32'(vecs[i].exp_rd));
      check($sformatf("vec%0d_cs_n", i), 32'(SPI_CS_n), 32'(vecs[i].exp_cs_n));
      check($sformatf("vec%0d_io", i), 32'(IO_PORT), 32'(vecs[i].exp_io));
    end

    // Fastest SCK with loopback
    wreg(AddrCtrl, 8'h38);
    check("a5_cs_n", 32'(SPI_CS_n), 32'd0);
    check("a5_io", 32'(IO_PORT), 32'd3);
    start_xfer("a5", 8'hA5, 1'b1, 8'h00, acc);
    finish_xfer("a5", 0, 8'hA5, 8'hA5, acc, 8'h02);

    // Slowest SCK, MISO held high
    wreg(AddrCtrl, 8'h07);
    check("3c_io", 32'(IO_PORT), 32'd0);
    start_xfer("3c", 8'h3C, 1'b0, 8'hFF, acc);
    finish_xfer("3c", 7, 8'h3C, 8'hFF, acc, 8'h02);

    // DATA write while busy is dropped and flags OVR
    wreg(AddrCtrl, 8'h01);
    start_xfer("ovr", 8'h0F, 1'b1, 8'h00, acc);
    wait_falls("ovr_mid", 2);
    wreg(AddrData, 8'h55);
    rreg(AddrStatus, rd);
    check("ovr_status_mid", 32'(rd), 32'h05);
    finish_xfer("ovr", 1, 8'h0F, 8'h0F, acc, 8'h06);
    wreg(AddrStatus, 8'h00);
    rreg(AddrStatus, rd);
    check("ovr_cleared", 32'(rd), 32'h00);

    // REG_SEL held for 5 cycles gives one acknowledge
    nack = 0;
    rd = 8'hEE;
    @(negedge CPU_CLK);
    REG_SEL  = 1'b1;
    REG_WR   = 1'b0;
    REG_ADDR = AddrRsvd;
    for (int i = 0; i < 5; i++) begin
      @(negedge CPU_CLK);
      if (REG_ACK) begin
        nack++;
        rd = REG_RDATA;
      end
    end
    REG_SEL = 1'b0;
    check("hold_ack_count", 32'(nack), 32'd1);
    check("hold_rsvd_rd", 32'(rd), 32'h00);
    rreg(AddrCtrl, rd);
    check("hold_rearm", 32'(rd), 32'h01);

    // DATA read accepted on the completion edge returns the previous byte
    wreg(AddrCtrl, 8'h00);
    start_xfer("sim", 8'h96, 1'b1, 8'h00, acc);
    for (int g = 0; g < 100 && cyc < acc + 14; g++) @(negedge CPU_CLK);
    check("sim_align", 32'(cyc), 32'(acc + 14));
    rreg(AddrData, rd);
    check("sim_old_byte", 32'(rd), 32'h0F);
    rreg(AddrStatus, rd);
    check("sim_done_kept", 32'(rd), 32'h02);
    rreg(AddrData, rd);
    check("sim_new_byte", 32'(rd), 32'h96);
    rreg(AddrStatus, rd);
    check("sim_done_clr", 32'(rd), 32'h00);

    // Reset in the middle of a transfer
    wreg(AddrCtrl, 8'h39);
    start_xfer("rst", 8'hC3, 1'b1, 8'h00, acc);
    wait_falls("rst_mid", 3);
    @(negedge CPU_CLK);
    #2 RESET_n = 1'b0;
    #1;
    check("mid_rst_sck", 32'(SPI_SCK), 32'd0);
    check("mid_rst_mosi", 32'(SPI_MOSI), 32'd1);
    check("mid_rst_cs_n", 32'(SPI_CS_n), 32'd1);
    check("mid_rst_io", 32'(IO_PORT), 32'd0);
    repeat (2) @(negedge CPU_CLK);
    RESET_n = 1'b1;
    rreg(AddrStatus, rd);
    check("mid_rst_status", 32'(rd), 32'h00);
    rreg(AddrCtrl, rd);
    check("mid_rst_ctrl", 32'(rd), 32'h07);
    wreg(AddrCtrl, 8'h01);
    start_xfer("post", 8'h5A, 1'b0, 8'h81, acc);
    finish_xfer("post", 1, 8'h5A, 8'h81, acc, 8'h02);

    // Randomized transfers against the protocol model
    for (int t = 0; t < 12; t++) begin
      int         div;
      logic [1:0] io;
      logic       cs;
      logic [7:0] ctrl, tx, sb;
      bit         lp;
      string      nm;
      div  = $urandom_range(0, 2);
      io   = 2'($urandom_range(0, 3));
      cs   = 1'($urandom_range(0, 1));
      tx   = 8'($urandom);
      sb   = 8'($urandom);
      lp   = 1'($urandom_range(0, 1));
      ctrl = {2'b00, io, cs, 3'(div)};
      nm   = $sformatf("rnd%0d", t);
      wreg(AddrCtrl, ctrl);
      check({nm, "_io"}, 32'(IO_PORT), 32'(io));
      check({nm, "_cs_n"}, 32'(SPI_CS_n), 32'(!cs));
      rreg(AddrCtrl, rd);
      check({nm, "_ctrl"}, 32'(rd), 32'(ctrl));
      start_xfer(nm, tx, lp, sb, acc);
      finish_xfer(nm, div, tx, lp ? tx : sb, acc, 8'h02);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
